// File: rtl/video_pkg.sv
// Shared video definitions for the camera capture and VGA scan-out stages.
package video_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        RESYNC,
        VBLANK,
        ACTIVE
    } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Registered rise/fall detector; edges are reported in the cycle the new level is sampled.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 byte-stream capture: pairs bytes into 12-bit pixels and writes them linearly.
module ov7670_capture
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              line_err
);

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    cap_state_t state, state_next;

    logic vsync_rise, vsync_fall, href_rise, href_fall;
    logic start_frame, end_frame, capture, line_end;

    logic              phase;
    logic [3:0]        r_nib;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic              in_range;
    rgb444_t           pix;

    sync_edge u_vsync_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .level (cam_vsync),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    sync_edge u_href_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .level (cam_href),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, vsync_fall, href_rise};

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= RESYNC;
        else        state <= state_next;
    end

    // A VSYNC rise in ACTIVE takes priority over any byte or HREF edge in that cycle.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        capture     = 1'b0;
        line_end    = 1'b0;
        unique case (state)
            RESYNC: if (vsync_rise) state_next = VBLANK;
            VBLANK: begin
                if (!cam_vsync) begin
                    state_next  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    state_next = VBLANK;
                    end_frame  = 1'b1;
                end else if (cam_href) begin
                    capture = 1'b1;
                end else if (href_fall) begin
                    line_end = 1'b1;
                end
            end
            default: state_next = RESYNC;
        endcase
    end

    assign in_range = (row < ROW_W'(V_ACTIVE)) && (col < COL_W'(H_ACTIVE));

    always_comb begin
        pix.r = r_nib;
        pix.g = cam_data[7:4];
        pix.b = cam_data[3:0];
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            r_nib      <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (start_frame) begin
                phase    <= 1'b0;
                col      <= '0;
                row      <= '0;
                row_base <= '0;
                line_err <= 1'b0;
            end
            if (end_frame) begin
                frame_done <= 1'b1;
                phase      <= 1'b0;
            end
            if (capture) begin
                if (!phase) begin
                    r_nib <= cam_data[3:0];
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (in_range) begin
                        wr_en   <= 1'b1;
                        wr_addr <= row_base + ADDR_W'(col);
                        wr_data <= pix;
                    end
                    if (col < COL_W'(H_ACTIVE)) col <= col + 1'b1;
                end
            end
            // Row base only advances while in range so it never wraps past the buffer.
            if (line_end) begin
                if (phase) line_err <= 1'b1;
                phase <= 1'b0;
                col   <= '0;
                if (row < ROW_W'(V_ACTIVE)) begin
                    row      <= row + 1'b1;
                    row_base <= row_base + ADDR_W'(H_ACTIVE);
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture with a small 4x2 frame geometry.
module tb_ov7670_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 4;

    logic          pclk = 1'b0;
    logic          rst_n;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done;
    logic          line_err;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  cyc       = 0;
    int  fd_cnt    = 0;
    int  checks    = 0;
    int  passed    = 0;
    int  m_row     = 0;
    bit  capturing = 1'b0;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    always #5 pclk = ~pclk;

    // Drive one byte slot and record what the DUT registered at that edge.
    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        wr_t w;
        @(negedge pclk);
        cam_vsync = vs;
        cam_href  = hr;
        cam_data  = d;
        @(posedge pclk);
        #1;
        cyc++;
        if (wr_en === 1'b1) begin
            w.cyc = cyc; w.addr = wr_addr; w.data = wr_data;
            obs_q.push_back(w);
        end
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic push_exp(input int col, input logic [3:0] r, input logic [7:0] gb);
        wr_t w;
        if (capturing && m_row < V && col < H) begin
            w.cyc = cyc; w.addr = AW'(m_row * H + col); w.data = {r, gb};
            exp_q.push_back(w);
        end
    endtask

    task automatic cam_line(input int nbytes, input bit fixed);
        logic [7:0] b;
        logic [3:0] r;
        int col;
        col = 0;
        r   = '0;
        for (int i = 0; i < nbytes; i++) begin
            if (fixed) b = (i % 2 == 0) ? 8'h0A : 8'h5C;
            else       b = 8'($urandom);
            step(1'b0, 1'b1, b);
            if (i % 2 == 0) r = b[3:0];
            else begin
                push_exp(col, r, b);
                col++;
            end
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        m_row++;
    endtask

    task automatic frame_pulse();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        m_row     = 0;
        capturing = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        #23;
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, line_err} !== '0)
            $display("FAIL reset_outputs: got %b expected all zero", {wr_en, wr_addr, wr_data, frame_done, line_err});
        else passed++;
        @(negedge pclk) rst_n = 1'b1;
        cam_line(8, 1'b0);
        cam_line(7, 1'b0);
        checks++;
        if (obs_q.size() !== 0) $display("FAIL reset_no_writes: got %0d writes expected 0", obs_q.size());
        else passed++;
        frame_pulse();
        checks++;
        if (fd_cnt !== 0) $display("FAIL reset_first_vsync_done: got %0d pulses expected 0", fd_cnt);
        else passed++;
        checks++;
        if (line_err !== 1'b0) $display("FAIL reset_line_err: got %b expected 0", line_err);
        else passed++;
        obs_q.delete();
    endtask

    task automatic test_basic_frame();
        wr_t e, o;
        fd_cnt = 0;
        cam_line(2 * H, 1'b1);
        cam_line(2 * H, 1'b1);
        checks++;
        if (fd_cnt !== 0) $display("FAIL basic_done_early: got %0d expected 0", fd_cnt);
        else passed++;
        frame_pulse();
        checks++;
        if (fd_cnt !== 1) $display("FAIL basic_frame_done: got %0d pulses expected 1", fd_cnt);
        else passed++;
        checks++;
        if (line_err !== 1'b0) $display("FAIL basic_line_err: got %b expected 0", line_err);
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL basic_px: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        wr_t e, o;
        fd_cnt = 0;
        cam_line(2 * H, 1'b0);
        cam_line(2 * H, 1'b0);
        frame_pulse();
        cam_line(2 * H, 1'b0);
        cam_line(2 * H, 1'b0);
        frame_pulse();
        checks++;
        if (fd_cnt !== 2) $display("FAIL b2b_frame_done: got %0d pulses expected 2", fd_cnt);
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL b2b_px: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_odd_oversize_line();
        wr_t e, o;
        fd_cnt = 0;
        cam_line(2 * H + 3, 1'b0);
        checks++;
        if (line_err !== 1'b1) $display("FAIL odd_line_err_set: got %b expected 1", line_err);
        else passed++;
        cam_line(2 * H, 1'b0);
        checks++;
        if (line_err !== 1'b1) $display("FAIL odd_line_err_hold: got %b expected 1", line_err);
        else passed++;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        checks++;
        if (line_err !== 1'b1) $display("FAIL odd_line_err_vblank: got %b expected 1", line_err);
        else passed++;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        m_row = 0;
        checks++;
        if (line_err !== 1'b0) $display("FAIL odd_line_err_clear: got %b expected 0", line_err);
        else passed++;
        checks++;
        if (fd_cnt !== 1) $display("FAIL odd_frame_done: got %0d pulses expected 1", fd_cnt);
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL odd_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL odd_px: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_extra_lines();
        wr_t e, o;
        int max_addr;
        for (int l = 0; l < V + 2; l++) cam_line(2 * H, 1'b0);
        max_addr = 0;
        foreach (obs_q[i]) if (int'(obs_q[i].addr) > max_addr) max_addr = int'(obs_q[i].addr);
        checks++;
        if (max_addr > H * V - 1) $display("FAIL extra_max_addr: got %0d expected <= %0d", max_addr, H * V - 1);
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL extra_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL extra_px: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        frame_pulse();
    endtask

    task automatic test_vsync_midline();
        wr_t e, o;
        fd_cnt = 0;
        cam_line(2 * H, 1'b0);
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h96);
        push_exp(0, 4'hC, 8'h96);
        step(1'b0, 1'b1, 8'h07);
        step(1'b1, 1'b1, 8'hE1);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        m_row = 0;
        checks++;
        if (fd_cnt !== 1) $display("FAIL midline_frame_done: got %0d pulses expected 1", fd_cnt);
        else passed++;
        checks++;
        if (line_err !== 1'b0) $display("FAIL midline_line_err: got %b expected 0", line_err);
        else passed++;
        cam_line(2 * H, 1'b0);
        cam_line(2 * H, 1'b0);
        frame_pulse();
        checks++;
        if (fd_cnt !== 2) $display("FAIL midline_next_done: got %0d pulses expected 2", fd_cnt);
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL midline_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL midline_px: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        wr_t e, o;
        cam_line(2 * H, 1'b0);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        push_exp(0, 4'h2, 8'h34);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, frame_done, line_err} !== '0)
            $display("FAIL async_reset_outputs: got %b expected all zero", {wr_en, wr_addr, wr_data, frame_done, line_err});
        else passed++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL async_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data)
                $display("FAIL async_px: got cyc %0d addr %0d data %h expected cyc %0d addr %0d data %h", o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
        capturing = 1'b0;
        fd_cnt    = 0;
        @(negedge pclk) rst_n = 1'b1;
        cam_line(2 * H, 1'b0);
        cam_line(2 * H, 1'b0);
        frame_pulse();
        checks++;
        if (obs_q.size() !== 0 || fd_cnt !== 0)
            $display("FAIL async_resync: got %0d writes %0d pulses expected 0 and 0", obs_q.size(), fd_cnt);
        else passed++;
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_odd_oversize_line();
        test_extra_lines();
        test_vsync_midline();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
